// File: rtl/sprite_pkg.sv
// Shared types and fixed-point helpers for the sprite grid mover.
package sprite_pkg;

  typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;
  typedef enum logic [1:0] {ALIVE = 2'd0, DYING = 2'd1, RESPAWN = 2'd2, GAME_OVER = 2'd3} mover_state_t;

  localparam int CNT_W = 16;

  // Non-negative offset of a fixed-point coordinate inside its tile.
  function automatic logic signed [31:0] tile_offset(input logic signed [31:0] pos, input int shift);
    logic signed [31:0] mask;
    mask = (32'sd1 <<< shift) - 32'sd1;
    return pos & mask;
  endfunction

  function automatic logic signed [31:0] clamp_s32(input logic signed [31:0] v,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Current heading keeps priority while held; otherwise lowest set bit wins.
  function automatic dir_t resolve_dir(input logic [3:0] req, input dir_t cur);
    if (req[cur]) return cur;
    if (req[0]) return UP;
    if (req[1]) return RIGHT;
    if (req[2]) return DOWN;
    return LEFT;
  endfunction

endpackage

// File: rtl/grid_snap_step.sv
// One frame of grid motion: straight move when the cross axis is on a grid
// line, otherwise a snap of the cross axis toward the nearest line.
module grid_snap_step
  import sprite_pkg::*;
#(
  parameter int X_MIN     = 15,
  parameter int X_MAX     = 562,
  parameter int Y_MIN     = 160,
  parameter int Y_MAX     = 442,
  parameter int TILE_LOG2 = 5,
  parameter int FRAC_BITS = 6,
  parameter int SPEED     = 100,
  parameter int POS_W     = 11
) (
  input  logic signed [POS_W+FRAC_BITS-1:0] pos_x,
  input  logic signed [POS_W+FRAC_BITS-1:0] pos_y,
  input  logic                              req_valid,
  input  dir_t                              req_dir,
  input  logic [3:0]                        blocked,
  output logic signed [POS_W+FRAC_BITS-1:0] next_x,
  output logic signed [POS_W+FRAC_BITS-1:0] next_y,
  output logic                              turn
);

  localparam int PW      = POS_W + FRAC_BITS;
  localparam int TILE_FX = 1 << (TILE_LOG2 + FRAC_BITS);
  localparam int HALF_FX = TILE_FX / 2;
  localparam int X_LO    = X_MIN * (1 << FRAC_BITS);
  localparam int X_HI    = X_MAX * (1 << FRAC_BITS);
  localparam int Y_LO    = Y_MIN * (1 << FRAC_BITS);
  localparam int Y_HI    = Y_MAX * (1 << FRAC_BITS);

  logic              horiz;
  logic signed [31:0] main_pos, perp_pos, main_new, perp_new, off, step, nx, ny;

  always_comb begin
    horiz    = (req_dir == RIGHT) || (req_dir == LEFT);
    main_pos = horiz ? 32'(pos_x) : 32'(pos_y);
    perp_pos = horiz ? 32'(pos_y) : 32'(pos_x);
    off      = tile_offset(perp_pos, TILE_LOG2 + FRAC_BITS);
    main_new = main_pos;
    perp_new = perp_pos;
    step     = '0;
    turn     = 1'b0;
    if (req_valid) begin
      if (off == 32'sd0) begin
        turn = 1'b1;
        if (!blocked[req_dir])
          main_new = (req_dir == RIGHT || req_dir == DOWN) ? main_pos + SPEED : main_pos - SPEED;
      end else if (off < HALF_FX) begin
        // Step is capped by the remaining distance so the snap never overshoots.
        step     = (off < SPEED) ? off : SPEED;
        perp_new = perp_pos - step;
      end else begin
        step     = (TILE_FX - off < SPEED) ? TILE_FX - off : SPEED;
        perp_new = perp_pos + step;
      end
    end
    nx     = horiz ? main_new : perp_new;
    ny     = horiz ? perp_new : main_new;
    next_x = PW'(clamp_s32(nx, X_LO, X_HI));
    next_y = PW'(clamp_s32(ny, Y_LO, Y_HI));
  end

endmodule

// File: rtl/sprite_grid_mover.sv
// Per-frame sprite mover on a tile grid with turn assist, wall mask and a
// lives / death / respawn / game-over state machine.
module sprite_grid_mover
  import sprite_pkg::*;
#(
  parameter int INITIAL_X     = 240,
  parameter int INITIAL_Y     = 448,
  parameter int X_MIN         = 15,
  parameter int X_MAX         = 562,
  parameter int Y_MIN         = 160,
  parameter int Y_MAX         = 442,
  parameter int TILE_LOG2     = 5,
  parameter int FRAC_BITS     = 6,
  parameter int SPEED         = 100,
  parameter int POS_W         = 11,
  parameter int LIVES         = 3,
  parameter int DEATH_FRAMES  = 256,
  parameter int INVULN_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [3:0]              dir_req,
  input  logic [3:0]              blocked,
  input  logic                    kill,
  input  logic                    restart,
  output logic signed [POS_W-1:0] topLeftX,
  output logic signed [POS_W-1:0] topLeftY,
  output logic [1:0]              player_direction,
  output logic [2:0]              image,
  output logic                    player_awake,
  output logic                    invulnerable,
  output logic [2:0]              lives_left,
  output logic                    game_over
);

  localparam int PW = POS_W + FRAC_BITS;
  localparam logic signed [PW-1:0] INIT_X_FX = PW'(INITIAL_X * (1 << FRAC_BITS));
  localparam logic signed [PW-1:0] INIT_Y_FX = PW'(INITIAL_Y * (1 << FRAC_BITS));

  mover_state_t        state_reg, state_next;
  logic signed [PW-1:0] pos_x_reg, pos_x_next, pos_y_reg, pos_y_next, snap_x, snap_y;
  dir_t                dir_reg, dir_next, req_dir;
  logic [2:0]          lives_reg, lives_next, move_cnt_reg, move_cnt_next, image_reg, image_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                kill_pend_reg, kill_pend_next;
  logic                awake_reg, awake_next, invuln_reg, invuln_next, over_reg, over_next;
  logic                req_valid, snap_turn, do_motion;

  assign req_valid = |dir_req;
  assign req_dir   = resolve_dir(dir_req, dir_reg);

  grid_snap_step #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .TILE_LOG2(TILE_LOG2), .FRAC_BITS(FRAC_BITS), .SPEED(SPEED), .POS_W(POS_W)
  ) u_step (
    .pos_x(pos_x_reg), .pos_y(pos_y_reg), .req_valid(req_valid), .req_dir(req_dir),
    .blocked(blocked), .next_x(snap_x), .next_y(snap_y), .turn(snap_turn)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= ALIVE;
      pos_x_reg     <= INIT_X_FX;
      pos_y_reg     <= INIT_Y_FX;
      dir_reg       <= LEFT;
      lives_reg     <= 3'(LIVES);
      cnt_reg       <= '0;
      move_cnt_reg  <= '0;
      kill_pend_reg <= 1'b0;
      image_reg     <= '0;
      awake_reg     <= 1'b1;
      invuln_reg    <= 1'b0;
      over_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_x_reg     <= pos_x_next;
      pos_y_reg     <= pos_y_next;
      dir_reg       <= dir_next;
      lives_reg     <= lives_next;
      cnt_reg       <= cnt_next;
      move_cnt_reg  <= move_cnt_next;
      kill_pend_reg <= kill_pend_next;
      image_reg     <= image_next;
      awake_reg     <= awake_next;
      invuln_reg    <= invuln_next;
      over_reg      <= over_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pos_x_next     = pos_x_reg;
    pos_y_next     = pos_y_reg;
    dir_next       = dir_reg;
    lives_next     = lives_reg;
    cnt_next       = cnt_reg;
    move_cnt_next  = move_cnt_reg;
    image_next     = image_reg;
    do_motion      = 1'b0;
    kill_pend_next = (state_reg == ALIVE) ? (kill_pend_reg | kill) : 1'b0;

    unique case (state_reg)
      ALIVE: if (startOfFrame) begin
        kill_pend_next = 1'b0;
        // A kill pending at the frame boundary wins over that frame's motion.
        if (kill_pend_reg || kill) begin
          state_next = DYING;
          cnt_next   = '0;
        end else begin
          do_motion = 1'b1;
        end
      end
      DYING: if (startOfFrame) begin
        if (cnt_reg == CNT_W'(DEATH_FRAMES - 1)) begin
          cnt_next = '0;
          if (lives_reg > 3'd1) begin
            lives_next = lives_reg - 3'd1;
            state_next = RESPAWN;
            pos_x_next = INIT_X_FX;
            pos_y_next = INIT_Y_FX;
          end else begin
            lives_next = '0;
            state_next = GAME_OVER;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESPAWN: if (startOfFrame) begin
        do_motion = 1'b1;
        if (cnt_reg == CNT_W'(INVULN_FRAMES - 1)) begin
          state_next = ALIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAME_OVER: if (restart) begin
        state_next    = ALIVE;
        lives_next    = 3'(LIVES);
        pos_x_next    = INIT_X_FX;
        pos_y_next    = INIT_Y_FX;
        dir_next      = LEFT;
        cnt_next      = '0;
        move_cnt_next = '0;
        image_next    = '0;
      end
      default: ;
    endcase

    if (do_motion) begin
      pos_x_next = snap_x;
      pos_y_next = snap_y;
      if (snap_turn) dir_next = req_dir;
      if (req_valid) move_cnt_next = move_cnt_reg + 3'd1;
    end

    unique case (state_next)
      ALIVE:   if (do_motion) image_next = req_valid ? move_cnt_next : 3'd0;
      DYING:   image_next = (cnt_next > CNT_W'(255)) ? 3'd7 : cnt_next[7:5];
      RESPAWN: image_next = cnt_next[2:0];
      default: image_next = 3'd7;
    endcase

    awake_next  = (state_next == ALIVE) || (state_next == RESPAWN);
    invuln_next = (state_next == RESPAWN);
    over_next   = (state_next == GAME_OVER);
  end

  assign topLeftX         = pos_x_reg[PW-1:FRAC_BITS];
  assign topLeftY         = pos_y_reg[PW-1:FRAC_BITS];
  assign player_direction = dir_reg;
  assign image            = image_reg;
  assign player_awake     = awake_reg;
  assign invulnerable     = invuln_reg;
  assign lives_left       = lives_reg;
  assign game_over        = over_reg;

endmodule

// File: tb/tb_sprite_grid_mover.sv
// Directed bench for sprite_grid_mover: motion, snapping, clamping, blocking
// and the full death / respawn / game-over cycle.
module tb_sprite_grid_mover;

  logic              clk = 1'b0;
  logic              resetN, startOfFrame, kill, restart;
  logic [3:0]        dir_req, blocked;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0]        player_direction;
  logic [2:0]        image, lives_left;
  logic              player_awake, invulnerable, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_grid_mover #(.SPEED(64), .Y_MAX(462)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .dir_req(dir_req),
    .blocked(blocked), .kill(kill), .restart(restart), .topLeftX(topLeftX),
    .topLeftY(topLeftY), .player_direction(player_direction), .image(image),
    .player_awake(player_awake), .invulnerable(invulnerable),
    .lives_left(lives_left), .game_over(game_over)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the frame.
  task automatic frame();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic frame_kill();
    kill = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; kill = 1'b0; restart = 1'b0;
    dir_req = 4'b0000; blocked = 4'b0000;
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    check("rst_x", topLeftX, 240);
    check("rst_y", topLeftY, 448);
    check("rst_dir", player_direction, 3);
    check("rst_lives", lives_left, 3);
    check("rst_awake", player_awake, 1);
    check("rst_over", game_over, 0);
    check("rst_inv", invulnerable, 0);
    check("rst_image", image, 0);

    // Straight move right along an aligned row.
    dir_req = 4'b0010;
    frame();
    check("right1_x", topLeftX, 241);
    check("right1_dir", player_direction, 1);
    check("right1_image", image, 1);
    frames(9);
    check("right10_x", topLeftX, 250);
    check("right10_y", topLeftY, 448);
    check("right10_image", image, 2);
    repeat (4) @(negedge clk);
    check("no_sof_x", topLeftX, 250);
    dir_req = 4'b0000;
    frame();
    check("idle_image", image, 0);
    check("idle_x", topLeftX, 250);

    // Asynchronous reset while moving.
    dir_req = 4'b0010;
    frame();
    check("pre_rst_x", topLeftX, 251);
    resetN = 1'b0;
    #1;
    check("midrst_x", topLeftX, 240);
    check("midrst_dir", player_direction, 3);
    @(negedge clk);
    resetN = 1'b1;

    // Snap from exactly half a tile rounds up; blocked does not stop snapping.
    dir_req = 4'b0001; blocked = 4'b0001;
    frame();
    check("snap1_x", topLeftX, 241);
    check("snap1_dir", player_direction, 3);
    frames(15);
    check("snap16_x", topLeftX, 256);
    check("snap16_dir", player_direction, 3);
    frame();
    check("turn_up_dir", player_direction, 0);
    check("blocked_up_y", topLeftY, 448);
    blocked = 4'b0000;
    frame();
    check("up_y", topLeftY, 447);

    // Small offset above half snaps up to the line, then turn right.
    dir_req = 4'b0010;
    frame();
    check("snapy_y", topLeftY, 448);
    check("snapy_dir", player_direction, 0);
    frame();
    check("turn_right_dir", player_direction, 1);
    check("turn_right_x", topLeftX, 257);
    frames(2);
    check("right_259", topLeftX, 259);

    // Offset below half snaps down, then turn down.
    dir_req = 4'b0100;
    frame();
    check("snapdn1_x", topLeftX, 258);
    check("snapdn1_dir", player_direction, 1);
    frames(2);
    check("snapdn3_x", topLeftX, 256);
    frame();
    check("down_dir", player_direction, 2);
    check("down_y", topLeftY, 449);

    // Request resolution with opposite pairs held.
    dir_req = 4'b0101;
    frame();
    check("pair_cur_y", topLeftY, 450);
    check("pair_cur_dir", player_direction, 2);
    dir_req = 4'b1010;
    frame();
    check("pair_low_y", topLeftY, 449);
    check("pair_low_dir", player_direction, 2);
    frame();
    frame();
    check("pair_turn_x", topLeftX, 257);
    check("pair_turn_dir", player_direction, 1);

    // Clamp at the right bound.
    dir_req = 4'b0010;
    frames(305);
    check("clamp_reach_x", topLeftX, 562);
    frames(2);
    check("clamp_hold_x", topLeftX, 562);

    // Wall mask: turn happens, motion does not.
    dir_req = 4'b1000; blocked = 4'b1000;
    frame();
    check("blk_left_dir", player_direction, 3);
    check("blk_left_x", topLeftX, 562);
    blocked = 4'b0000;
    frame();
    check("left_x", topLeftX, 561);

    // Kill on the frame cycle: dying, frozen.
    dir_req = 4'b0000;
    frame_kill();
    check("die_awake", player_awake, 0);
    check("die_x", topLeftX, 561);
    check("die_image", image, 0);
    check("die_lives", lives_left, 3);
    dir_req = 4'b0010;
    frames(255);
    check("dying_image", image, 7);
    check("dying_awake", player_awake, 0);
    check("dying_x", topLeftX, 561);
    dir_req = 4'b0000;
    frame();
    check("resp_lives", lives_left, 2);
    check("resp_awake", player_awake, 1);
    check("resp_inv", invulnerable, 1);
    check("resp_x", topLeftX, 240);
    check("resp_y", topLeftY, 448);
    check("resp_image", image, 0);

    // Kill during respawn is ignored.
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    @(negedge clk);
    frame();
    check("resp1_image", image, 1);
    check("resp1_inv", invulnerable, 1);
    frames(62);
    check("resp63_inv", invulnerable, 1);
    check("resp63_image", image, 7);
    frame();
    check("alive_inv", invulnerable, 0);
    check("alive_awake", player_awake, 1);
    check("alive_lives", lives_left, 2);

    // Kill off the frame cycle is latched until the next frame.
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    repeat (3) @(negedge clk);
    check("latch_awake", player_awake, 1);
    frame();
    check("latch_die_awake", player_awake, 0);
    frames(256);
    check("resp2_lives", lives_left, 1);
    check("resp2_inv", invulnerable, 1);
    frames(64);
    check("alive2_inv", invulnerable, 0);

    // Last life: game over, then restart.
    frame_kill();
    frames(256);
    check("go_over", game_over, 1);
    check("go_lives", lives_left, 0);
    check("go_image", image, 7);
    check("go_awake", player_awake, 0);
    dir_req = 4'b0010;
    frame();
    check("go_frozen_x", topLeftX, 240);
    dir_req = 4'b0000;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_lives", lives_left, 3);
    check("rs_over", game_over, 0);
    check("rs_awake", player_awake, 1);
    check("rs_dir", player_direction, 3);
    check("rs_x", topLeftX, 240);
    check("rs_image", image, 0);
    dir_req = 4'b0010;
    frame();
    check("rs_move_x", topLeftX, 241);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
